// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the 16-bit core's instruction memory.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [10:0]           words_loaded
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CNT_HI = 4'd1;
    localparam logic [3:0] S_CNT_LO = 4'd2;
    localparam logic [3:0] S_D_HI   = 4'd3;
    localparam logic [3:0] S_D_LO   = 4'd4;
    localparam logic [3:0] S_WR     = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;
    localparam logic [3:0] S_ERROR  = 4'd7;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CHK    = 4'd8;
`endif

    localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

    logic [3:0]            r_state;
    logic [3:0]            w_state_nx;
    logic                  r_ready;
    logic                  r_we;
    logic                  r_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [10:0]           r_words;
    logic [7:0]            r_cnt_hi;
    logic [7:0]            r_hi;
    logic [15:0]           r_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_xor;
`endif

    logic                  w_xfer;
    logic [15:0]           w_n;
    logic [10:0]           w_words_inc;
    logic                  w_last;
    logic                  w_busy_nx;
    logic                  w_ready_nx;

    assign w_xfer      = in_valid & r_ready;
    assign w_n         = {r_cnt_hi, in_data};
    assign w_words_inc = r_words + 11'd1;
    assign w_last      = ({5'd0, w_words_inc} == r_n);

    // Frame sequencing: count bytes, then hi/lo/write per word.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_state_nx = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (w_xfer) w_state_nx = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (w_xfer) begin
                    if (w_n == 16'd0)
                        w_state_nx = S_DONE;
                    else if ({1'b0, w_n} > LP_DEPTH)
                        w_state_nx = S_ERROR;
                    else
                        w_state_nx = S_D_HI;
                end
            end
            S_D_HI: begin
                if (w_xfer) w_state_nx = S_D_LO;
            end
            S_D_LO: begin
                if (w_xfer) w_state_nx = S_WR;
            end
            S_WR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_state_nx = w_last ? S_CHK : S_D_HI;
`else
                w_state_nx = w_last ? S_DONE : S_D_HI;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer)
                    w_state_nx = (in_data == r_xor) ? S_DONE : S_ERROR;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Decode the state being entered into registered status flags.
    always_comb begin
        w_ready_nx = (w_state_nx == S_CNT_HI) || (w_state_nx == S_CNT_LO) ||
                     (w_state_nx == S_D_HI)   || (w_state_nx == S_D_LO);
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_ready_nx = w_ready_nx || (w_state_nx == S_CHK);
`endif
        w_busy_nx  = w_ready_nx || (w_state_nx == S_WR);
    end

    // State and handshake/status flags; all follow the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ready <= w_ready_nx;
            r_we    <= (w_state_nx == S_WR);
            r_busy  <= w_busy_nx;
            r_hold  <= w_busy_nx || (w_state_nx == S_ERROR);
            r_done  <= (w_state_nx == S_DONE);
            r_error <= (w_state_nx == S_ERROR);
        end
    end

    // Byte capture, word assembly, address and word counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_words  <= '0;
            r_cnt_hi <= '0;
            r_hi     <= '0;
            r_n      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) r_words <= '0;
                end
                S_CNT_HI: begin
                    if (w_xfer) r_cnt_hi <= in_data;
                end
                S_CNT_LO: begin
                    if (w_xfer) begin
                        r_n    <= w_n;
                        r_addr <= '0;
                    end
                end
                S_D_HI: begin
                    if (w_xfer) r_hi <= in_data;
                end
                S_D_LO: begin
                    if (w_xfer) r_wdata <= DATA_WIDTH'({r_hi, in_data});
                end
                S_WR: begin
                    r_words <= w_words_inc;
                    // Last address is held so it never steps past DEPTH-1.
                    if (!w_last) r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of every accepted frame byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xor <= '0;
        end else if (start && !r_busy) begin
            r_xor <= '0;
        end else if (w_xfer) begin
            r_xor <= r_xor ^ in_data;
        end
    end
`endif

    assign in_ready     = r_ready;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign cpu_hold     = r_hold;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames plus hand sequences for imem_loader.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to cover the checksum variant.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nb;
        logic [63:0] fr;
        bit          has_ck;
        logic [7:0]  ck;
        int          nw;
        logic [63:0] wd;
        bit          rnd;
        logic        e_done;
        logic        e_err;
        logic        e_hold;
        logic [10:0] e_wl;
    } vec_t;

    vec_t        vt [8];
    int          nv;
    int          checks;
    int          failures;
    logic [7:0]  tx_q [$];
    logic [15:0] exp_w [$];
    logic [25:0] wr_log [$];
    logic        prev_we;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe lasts one cycle and never overlaps in_ready.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_log.push_back({mem_addr, mem_wdata});
            checks++;
            if (in_ready !== 1'b0 || prev_we) begin
                failures++;
                $display("FAIL wr_cycle: in_ready=%0b prev_we=%0b want 0 0",
                         in_ready, prev_we);
            end
        end
        prev_we = mem_we;
    end

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".error"}, 32'(error), 32'd0);
        check({tag, ".words"}, 32'(words_loaded), 32'd0);
    endtask

    // All drive tasks start and end at posedge + 1.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit got;
        int n;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        got = 1'b0;
        n = 0;
        while (!got && n < 64) begin
            got = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_byte: byte 0x%0h not accepted in 64 cycles", b);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(done || error)) begin
            checks++;
            failures++;
            $display("FAIL %s.end: done=%0b error=%0b after 64 cycles, want end",
                     tag, done, error);
        end
    endtask

    task automatic check_writes(input string tag);
        int bad;
        check({tag, ".wr_count"}, 32'(wr_log.size()), 32'(exp_w.size()));
        if (exp_w.size() > 0) begin
            bad = -1;
            for (int i = 0; i < wr_log.size() && i < exp_w.size(); i++) begin
                if (wr_log[i] !== {10'(i), exp_w[i]}) begin
                    bad = i;
                    break;
                end
            end
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s.writes: entry %0d addr=%0h data=%0h want addr=%0h data=%0h",
                         tag, bad, wr_log[bad][25:16], wr_log[bad][15:0],
                         bad, exp_w[bad]);
            end
        end
    endtask

    task automatic run_frame(input string tag, input bit rnd,
                             input logic e_done, input logic e_err,
                             input logic e_hold, input logic [10:0] e_wl);
        wr_log.delete();
        do_start();
        check({tag, ".st_busy"}, 32'(busy), 32'd1);
        check({tag, ".st_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, ".st_flags"}, 32'({done, error}), 32'd0);
        check({tag, ".st_words"}, 32'(words_loaded), 32'd0);
        foreach (tx_q[i]) send_byte(tx_q[i], rnd);
        wait_end(tag);
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".error"}, 32'(error), 32'(e_err));
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(e_hold));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".words"}, 32'(words_loaded), 32'(e_wl));
        check_writes(tag);
    endtask

    task automatic load_vec(input int k);
        tx_q.delete();
        exp_w.delete();
        for (int i = 0; i < vt[k].nb; i++)
            tx_q.push_back(vt[k].fr[8*(vt[k].nb-1-i) +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (vt[k].has_ck) tx_q.push_back(vt[k].ck);
`endif
        for (int i = 0; i < vt[k].nw; i++)
            exp_w.push_back(vt[k].wd[16*(vt[k].nw-1-i) +: 16]);
    endtask

    initial begin
        logic [7:0]  x;
        logic [15:0] w16;
        checks   = 0;
        failures = 0;
        prev_we  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;

        vt[0] = '{nb:6, fr:64'h0002_1234_ABCD, has_ck:1'b1, ck:8'h42,
                  nw:2, wd:64'h1234_ABCD, rnd:1'b0,
                  e_done:1'b1, e_err:1'b0, e_hold:1'b0, e_wl:11'd2};
        vt[1] = '{nb:2, fr:64'h0000, has_ck:1'b0, ck:8'h00,
                  nw:0, wd:64'h0, rnd:1'b0,
                  e_done:1'b1, e_err:1'b0, e_hold:1'b0, e_wl:11'd0};
        vt[2] = '{nb:2, fr:64'h0401, has_ck:1'b0, ck:8'h00,
                  nw:0, wd:64'h0, rnd:1'b0,
                  e_done:1'b0, e_err:1'b1, e_hold:1'b1, e_wl:11'd0};
        vt[3] = '{nb:4, fr:64'h0001_BEEF, has_ck:1'b1, ck:8'h50,
                  nw:1, wd:64'hBEEF, rnd:1'b0,
                  e_done:1'b1, e_err:1'b0, e_hold:1'b0, e_wl:11'd1};
        vt[4] = '{nb:8, fr:64'h0003_1122_3344_5566, has_ck:1'b1, ck:8'h74,
                  nw:3, wd:64'h1122_3344_5566, rnd:1'b1,
                  e_done:1'b1, e_err:1'b0, e_hold:1'b0, e_wl:11'd3};
        vt[5] = vt[4];
        vt[5].rnd = 1'b0;
        nv = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
        vt[6] = '{nb:4, fr:64'h0001_1234, has_ck:1'b1, ck:8'h27,
                  nw:1, wd:64'h1234, rnd:1'b0,
                  e_done:1'b1, e_err:1'b0, e_hold:1'b0, e_wl:11'd1};
        vt[7] = '{nb:4, fr:64'h0001_1234, has_ck:1'b1, ck:8'h00,
                  nw:1, wd:64'h1234, rnd:1'b0,
                  e_done:1'b0, e_err:1'b1, e_hold:1'b1, e_wl:11'd1};
        nv = 8;
`endif

        @(posedge clk); #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < nv; k++) begin
            load_vec(k);
            run_frame($sformatf("v%0d", k), vt[k].rnd, vt[k].e_done,
                      vt[k].e_err, vt[k].e_hold, vt[k].e_wl);
        end

        // Zero count: DONE right after the low count byte.
        wr_log.delete();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("zero.done", 32'(done), 32'd1);
        check("zero.busy_hold", 32'({busy, cpu_hold}), 32'd0);
        check("zero.wr_count", 32'(wr_log.size()), 32'd0);

        // Write timing, plus a start pulse that must be ignored.
        wr_log.delete();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        do_start();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("wt.we", 32'(mem_we), 32'd1);
        check("wt.ready", 32'(in_ready), 32'd0);
        check("wt.addr", 32'(mem_addr), 32'd0);
        check("wt.wdata", 32'(mem_wdata), 32'h1234);
        @(posedge clk); #1;
        check("wt.we_off", 32'(mem_we), 32'd0);
        check("wt.words", 32'(words_loaded), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h27, 1'b0);
`endif
        wait_end("wt");
        check("wt.done", 32'(done), 32'd1);
        exp_w.delete();
        exp_w.push_back(16'h1234);
        check_writes("wt");

        // Asynchronous reset after the first word's high byte.
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        #2 reset = 1'b1;
        #1 check_idle("arst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        load_vec(0);
        run_frame("after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 11'd2);

        // Full-depth frame: 1024 words, address ends at 1023.
        tx_q.delete();
        exp_w.delete();
        tx_q.push_back(8'h04);
        tx_q.push_back(8'h00);
        x = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w16 = 16'(i * 37 + 5);
            tx_q.push_back(w16[15:8]);
            tx_q.push_back(w16[7:0]);
            exp_w.push_back(w16);
            x = x ^ w16[15:8] ^ w16[7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(x);
`endif
        run_frame("depth", 1'b0, 1'b1, 1'b0, 1'b0, 11'd1024);
        check("depth.addr", 32'(mem_addr), 32'd1023);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
